seg7_decimals_decoder: RTL

Recovers the decimals-count value from the 7-segment drive pattern that the decimals display decoder produces. It is the reverse path of that decoder. The block samples the active-low segment bus and waits until the pattern has been stable for a programmable number of cycles. It then decodes the pattern to a 3-bit value with status flags and presents the result on a valid/ready handshake. It sits in the display loopback/self-check path, between the segment register and the checker logic.

---
 rtl/seg7_decimals_decoder_if.sv | 36 +++
 rtl/seg7_decimals_decoder.sv | 115 +++++++++++
 2 files changed

// File: rtl/seg7_decimals_decoder_if.sv
// rtl/seg7_decimals_decoder_if.sv - segment input and decoded-word handshake bundle (err_cnt present with SEG7_DEC_ERRCNT_EN)
interface seg7_decimals_decoder_if;
    logic [6:0] seg_in;
    logic [2:0] out_decimals;
    logic       out_err;
    logic       out_bad;
    logic       out_valid;
    logic       out_ready;
`ifdef SEG7_DEC_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    modport master (
        input  seg_in,
        input  out_ready,
        output out_decimals,
        output out_err,
        output out_bad,
`ifdef SEG7_DEC_ERRCNT_EN
        output err_cnt,
`endif
        output out_valid
    );

    modport slave (
        output seg_in,
        output out_ready,
        input  out_decimals,
        input  out_err,
        input  out_bad,
`ifdef SEG7_DEC_ERRCNT_EN
        input  err_cnt,
`endif
        input  out_valid
    );
endinterface

// File: rtl/seg7_decimals_decoder.sv
// rtl/seg7_decimals_decoder.sv - debounced 7-segment to decimals-count decoder; SEG7_DEC_ERRCNT_EN adds err_cnt
module seg7_decimals_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    seg7_decimals_decoder_if.master      io
);
    typedef enum logic [1:0] {SETTLE, STABLE, HOLD} state_t;

    localparam logic [6:0] BLANK    = 7'b1111111;
    localparam logic [7:0] STABLE_V = 8'(STABLE_CYCLES);

    state_t     state, state_nx;
    logic [6:0] seg_q;
    logic [6:0] last_pat, last_pat_nx;
    logic [7:0] cnt, cnt_nx;
    logic [2:0] dec_q, dec_nx;
    logic       err_q, err_nx;
    logic       bad_q, bad_nx;
    logic       stable_nx;
    logic       slot_free;

    // Result packed as {err, bad, value}
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b1000000: decode = {2'b00, 3'd0};
            7'b1111001: decode = {2'b00, 3'd1};
            7'b0100100: decode = {2'b00, 3'd2};
            7'b0110000: decode = {2'b00, 3'd3};
            7'b0011001: decode = {2'b00, 3'd4};
            7'b0010010: decode = {2'b00, 3'd5};
            7'b0000110: decode = {2'b10, 3'd6};
            default:    decode = {2'b01, 3'd7};
        endcase
    endfunction

    // Decisions use the post-edge view of the window so that the word appears
    // on the same edge the counter reaches STABLE_CYCLES.
    always_comb begin
        cnt_nx      = cnt;
        last_pat_nx = last_pat;
        dec_nx      = dec_q;
        err_nx      = err_q;
        bad_nx      = bad_q;
        state_nx    = SETTLE;

        if (io.seg_in != seg_q)
            cnt_nx = 8'd1;
        else if (cnt >= STABLE_V)
            cnt_nx = STABLE_V;
        else
            cnt_nx = cnt + 8'd1;

        stable_nx = (cnt_nx == STABLE_V);
        slot_free = (state != HOLD) || io.out_ready;

        if (stable_nx && io.seg_in != last_pat) begin
            if (io.seg_in == BLANK) begin
                last_pat_nx = BLANK;
            end else if (slot_free) begin
                last_pat_nx              = io.seg_in;
                {err_nx, bad_nx, dec_nx} = decode(io.seg_in);
                state_nx                 = HOLD;
            end
        end

        if (state_nx != HOLD) begin
            if (state == HOLD && !io.out_ready)
                state_nx = HOLD;
            else if (stable_nx)
                state_nx = STABLE;
            else
                state_nx = SETTLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SETTLE;
            seg_q    <= BLANK;
            last_pat <= BLANK;
            cnt      <= 8'd1;
            dec_q    <= 3'd0;
            err_q    <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            seg_q    <= io.seg_in;
            last_pat <= last_pat_nx;
            cnt      <= cnt_nx;
            dec_q    <= dec_nx;
            err_q    <= err_nx;
            bad_q    <= bad_nx;
        end
    end

    assign io.out_valid    = (state == HOLD);
    assign io.out_decimals = dec_q;
    assign io.out_err      = err_q;
    assign io.out_bad      = bad_q;

`ifdef SEG7_DEC_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt_q <= 8'd0;
        else if (io.out_valid && io.out_ready && (err_q || bad_q) && err_cnt_q != 8'hFF)
            err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign io.err_cnt = err_cnt_q;
`endif
endmodule
